load_store_unit: RTL
====================

// Module: load_store_unit
// PURPOSE
//   MEM-stage access controller sitting directly upstream of data_memory.
//   Accepts one load/store request at a time from the pipeline (valid/ready).
//   Issues word-wide MR/MW cycles to data_memory and performs big-endian lane
//   selection with sign/zero extension on loads.
//   Does read-modify-write for byte and halfword stores; flags misaligned,
//   out-of-range and illegal requests without touching memory.
// PARAMETERS
//   ADDR_LIMIT  40  highest valid byte address; a word access needs aligned_addr+3 <= ADDR_LIMIT
// PORTS
//   clk           in   1   clock, all state updates on posedge
//   rst           in   1   synchronous, active-high reset
//   req_valid     in   1   request present
//   req_ready     out  1   unit idle, request accepted when req_valid & req_ready
//   req_load      in   1   load request
//   req_store     in   1   store request
//   req_size      in   2   00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  in   1   loads: 1 zero-extend, 0 sign-extend
//   req_addr      in   32  byte address
//   req_wdata     in   32  store data, right-justified (byte in [7:0], half in [15:0])
//   resp_valid    out  1   one-cycle pulse, response fields valid
//   resp_rdata    out  32  extended load data; 0 for stores and errors
//   resp_err      out  1   request rejected, no memory write performed
//   mem_mr        out  1   to data_memory MR
//   mem_mw        out  1   to data_memory MW
//   mem_add       out  32  to data_memory add, always word-aligned ({addr[31:2],2'b00})
//   mem_wd        out  32  to data_memory wd
//   mem_data      in   32  from data_memory data, valid the cycle after an MR cycle
// BEHAVIOUR
//   - Reset: state IDLE; req_ready, resp_valid, resp_err = 0; resp_rdata, mem_add, mem_wd = 0.
//   - Reset: mem_mr and mem_mw are forced to 0 combinationally while rst = 1.
//   - req_ready = 1 only in IDLE with rst = 0.
//   - On acceptance, capture all req_* fields; later req_* changes are ignored.
//   - States: IDLE, RD, WAIT, WR, DONE.
//       RD:   mem_mr = 1.
//       WR:   mem_mw = 1 with the merged word.
//       Other states: mem_mr = mem_mw = 0; the two are never both 1.
//   - Error on any of the following, taken as IDLE -> DONE with resp_err = 1 and no MR/MW:
//       load == store; size = 11; half with addr[0] = 1; word with addr[1:0] != 0;
//       {addr[31:2],2'b00} + 3 > ADDR_LIMIT.
//   - Load: IDLE -> RD -> WAIT -> DONE.
//       WAIT registers the extracted, extended data.
//       resp_valid is high 3 cycles after the acceptance edge.
//   - Word store: IDLE -> WR -> DONE; mem_wd = req_wdata; resp_valid after 2 cycles.
//   - Byte/half store: IDLE -> RD -> WAIT -> WR -> DONE.
//       WAIT registers mem_data with the target lane replaced.
//       resp_valid after 4 cycles.
//   - Big-endian lanes, o = addr[1:0]:
//       byte lane = mem_data[31-8*o -: 8];
//       half lane = o = 0 ? [31:16] : [15:0].
//   - Extension: unsigned -> zero-fill above the lane; signed -> replicate the lane MSB.
//   - DONE: resp_valid = 1 for exactly one cycle; next state IDLE.
//       resp_rdata and resp_err hold until the next DONE.
//   - Back-to-back: a new request may be accepted in the IDLE cycle right after DONE.
//   - Reset mid-operation: abort to IDLE, no response, memory unchanged for the aborted request.
// TESTING
//   - Reset preload mem[16] = 0x2D, mem[17..19] = 0.
//       load word @16 -> resp_rdata = 0x2D000000, err = 0, resp 3 cycles after accept.
//   - Load byte @16 signed -> 0x0000002D.
//       Then store byte 0x80 @17 (4-cycle RMW); load byte @17 signed -> 0xFFFFFF80.
//       Load byte @17 unsigned -> 0x00000080; load word @16 -> 0x2D800000.
//   - Store half 0xBEEF @18 then load half @18 signed -> 0xFFFFBEEF.
//       Word @16 = 0x2D80BEEF; store word 0x12345678 @20 -> mem_mw for exactly 1 cycle.
//   - Errors, each -> resp_err = 1, resp_rdata = 0, mem_mr/mem_mw never 1:
//       load half @17; load word @40; req_size = 11; req_load = req_store = 1.
//   - Assert rst during the WAIT cycle of store byte 0xAA @16.
//       No MW pulse, req_ready back to 1 after release, word @16 unchanged.
//   - Hold req_valid high with 3 queued loads.
//       Exactly one accepted per IDLE; resp_valid pulses one cycle each, in order.

Source files
------------

// File: rtl/load_store_unit.sv
// MEM-stage load/store controller in front of a word-wide data_memory.
// Big-endian lane select with sign/zero extension on loads, read-modify-write for sub-word stores.
module load_store_unit #(
    parameter int unsigned ADDR_LIMIT = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_mr,
    output logic        mem_mw,
    output logic [31:0] mem_add,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_data,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t state, state_next;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // req_ready is high only while idle, and the request fields are copied at that edge.
    logic        accept;
    logic        req_err;
    logic [32:0] last_byte;

    logic        load_q;
    logic        unsigned_q;
    logic [1:0]  size_q;
    logic [1:0]  off_q;
    logic [15:0] wdata_q;

    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign accept    = req_valid & req_ready;
    assign req_ready = (state == IDLE) & ~rst;
    assign mem_mr    = (state == RD) & ~rst;
    assign mem_mw    = (state == WR) & ~rst;
    assign resp_valid = (state == DONE) & ~rst;
    assign dbg_state = state;

    // Whole containing word must fit below the limit, even for byte accesses.
    assign last_byte = {1'b0, req_addr[31:2], 2'b00} + 33'd3;

    always_comb begin
        req_err = 1'b0;
        if (req_load == req_store)
            req_err = 1'b1;
        if (req_size == 2'b11)
            req_err = 1'b1;
        if ((req_size == 2'b01) && req_addr[0])
            req_err = 1'b1;
        if ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
        if (last_byte > 33'(ADDR_LIMIT))
            req_err = 1'b1;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_next = DONE;
                    else if (!req_load && (req_size == 2'b10))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = WAIT;
            WAIT:    state_next = load_q ? DONE : WR;
            WR:      state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Big-endian: byte offset 0 is the most significant lane of the word.
    always_comb begin
        lane_b = 8'h00;
        case (off_q)
            2'd0: lane_b = mem_data[31:24];
            2'd1: lane_b = mem_data[23:16];
            2'd2: lane_b = mem_data[15:8];
            2'd3: lane_b = mem_data[7:0];
            default: lane_b = 8'h00;
        endcase
        lane_h = (off_q == 2'd0) ? mem_data[31:16] : mem_data[15:0];
    end

    always_comb begin
        load_ext = mem_data;
        case (size_q)
            2'b00:   load_ext = {{24{~unsigned_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~unsigned_q & lane_h[15]}}, lane_h};
            default: load_ext = mem_data;
        endcase
    end

    always_comb begin
        merged = mem_data;
        if (size_q == 2'b01) begin
            if (off_q == 2'd0)
                merged[31:16] = wdata_q;
            else
                merged[15:0] = wdata_q;
        end else begin
            case (off_q)
                2'd0: merged[31:24] = wdata_q[7:0];
                2'd1: merged[23:16] = wdata_q[7:0];
                2'd2: merged[15:8]  = wdata_q[7:0];
                2'd3: merged[7:0]   = wdata_q[7:0];
                default: merged = mem_data;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_rdata <= 32'h0;
            resp_err   <= 1'b0;
            mem_add    <= 32'h0;
            mem_wd     <= 32'h0;
            load_q     <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            wdata_q    <= 16'h0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_q     <= req_load;
                        unsigned_q <= req_unsigned;
                        size_q     <= req_size;
                        off_q      <= req_addr[1:0];
                        wdata_q    <= req_wdata[15:0];
                        if (req_err) begin
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            mem_add <= {req_addr[31:2], 2'b00};
                            if (!req_load && (req_size == 2'b10))
                                mem_wd <= req_wdata;
                        end
                    end
                end
                WAIT: begin
                    if (load_q) begin
                        resp_rdata <= load_ext;
                        resp_err   <= 1'b0;
                    end else begin
                        mem_wd <= merged;
                    end
                end
                WR: begin
                    resp_rdata <= 32'h0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
